// File: rtl/scene_seq_ctrl_if.sv
// Signal bundle between the VGA timing / game logic side and the scene sequencer.
// scene_req_valid is a one-cycle strobe with no ready: in IDLE it is always taken and
// answered by scene_ack on the next cycle; while busy it is silently dropped.
interface scene_seq_ctrl_if;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic        blank;
  logic        frame_start;
  logic        scroll_left;
  logic        scroll_right;
  logic [1:0]  scene_req;
  logic        scene_req_valid;
  logic [17:0] rom_address;
  logic [1:0]  scene_sel;
  logic [3:0]  fade_level;
  logic [8:0]  scroll_x;
  logic        busy;
  logic        scene_ack;
  logic [1:0]  fsm_state;

  modport master (
    output drawX, drawY, blank, frame_start, scroll_left, scroll_right,
           scene_req, scene_req_valid,
    input  rom_address, scene_sel, fade_level, scroll_x, busy, scene_ack, fsm_state
  );

  modport slave (
    input  drawX, drawY, blank, frame_start, scroll_left, scroll_right,
           scene_req, scene_req_valid,
    output rom_address, scene_sel, fade_level, scroll_x, busy, scene_ack, fsm_state
  );
endinterface

// File: rtl/scene_seq_ctrl.sv
// Scene background sequencer: ROM address generation with horizontal scroll,
// scene selection and fade-out / swap / fade-in transitions.
module scene_seq_ctrl #(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 240,
  parameter int VIEW_W      = 320,
  parameter int SCROLL_STEP = 2,
  parameter int FADE_FRAMES = 4
) (
  input logic              vga_clk,
  input logic              reset,
  scene_seq_ctrl_if.slave  bus
);
  localparam int MAX_SCROLL = IMG_W - VIEW_W;
  localparam int CNT_W      = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [8:0]       STEP    = 9'(SCROLL_STEP);
  localparam logic [8:0]       MAX_SX  = 9'(MAX_SCROLL);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FADE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_SWAP     = 2'd2,
    S_FADE_IN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [17:0]      rom_address_q, rom_address_d;
  logic [1:0]       scene_sel_q, scene_sel_d;
  logic [1:0]       pending_q, pending_d;
  logic [3:0]       fade_level_q, fade_level_d;
  logic [8:0]       scroll_x_q, scroll_x_d;
  logic             busy_q, busy_d;
  logic             scene_ack_q, scene_ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [17:0] addr_sum;
  logic [8:0]  scroll_next;
  logic        cnt_hit;

  // Row stride is IMG_W; the screen is 2x upscaled so both coordinates are halved.
  assign addr_sum = 18'(18'(bus.drawY[9:1]) * IMG_W)
                  + 18'(bus.drawX[9:1])
                  + 18'(scroll_x_q);

  assign cnt_hit = (cnt_q == CNT_TOP);

  always_comb begin
    scroll_next = scroll_x_q;
    if (bus.scroll_left && !bus.scroll_right) begin
      scroll_next = (scroll_x_q < STEP) ? 9'd0 : scroll_x_q - STEP;
    end else if (bus.scroll_right && !bus.scroll_left) begin
      scroll_next = (scroll_x_q > MAX_SX - STEP) ? MAX_SX : scroll_x_q + STEP;
    end
  end

  always_comb begin
    state_d       = state_q;
    scene_sel_d   = scene_sel_q;
    pending_d     = pending_q;
    fade_level_d  = fade_level_q;
    scroll_x_d    = scroll_x_q;
    busy_d        = busy_q;
    scene_ack_d   = 1'b0;
    cnt_d         = cnt_q;
    rom_address_d = bus.blank ? addr_sum : 18'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) scroll_x_d = scroll_next;
        // A coincident frame pulse does not count toward the fade: counter restarts at 0.
        if (bus.scene_req_valid) begin
          scene_ack_d = 1'b1;
          if (bus.scene_req != scene_sel_q) begin
            pending_d = bus.scene_req;
            busy_d    = 1'b1;
            cnt_d     = '0;
            state_d   = S_FADE_OUT;
          end
        end
      end
      S_FADE_OUT: begin
        if (bus.frame_start) begin
          if (cnt_hit) begin
            cnt_d        = '0;
            fade_level_d = fade_level_q - 4'd1;
            if (fade_level_q == 4'd1) state_d = S_SWAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SWAP: begin
        if (bus.frame_start) begin
          scene_sel_d = pending_q;
          scroll_x_d  = 9'd0;
          state_d     = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        if (bus.frame_start) begin
          if (cnt_hit) begin
            cnt_d        = '0;
            fade_level_d = fade_level_q + 4'd1;
            if (fade_level_q == 4'd14) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_address_q <= 18'd0;
      scene_sel_q   <= 2'd0;
      pending_q     <= 2'd0;
      fade_level_q  <= 4'd15;
      scroll_x_q    <= 9'd0;
      busy_q        <= 1'b0;
      scene_ack_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      scene_sel_q   <= scene_sel_d;
      pending_q     <= pending_d;
      fade_level_q  <= fade_level_d;
      scroll_x_q    <= scroll_x_d;
      busy_q        <= busy_d;
      scene_ack_q   <= scene_ack_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.scene_sel   = scene_sel_q;
  assign bus.fade_level  = fade_level_q;
  assign bus.scroll_x    = scroll_x_q;
  assign bus.busy        = busy_q;
  assign bus.scene_ack   = scene_ack_q;
  assign bus.fsm_state   = state_q;
endmodule
